// File: rtl/spi_pkg.sv
// spi_pkg: shared types for the multi-channel SPI master
package spi_pkg;
  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} spi_state_e;
  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period tick generator, reloaded with the latched divisor on every start
module spi_clk_div #(
  parameter int DVSR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              en_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  output logic              tick_o
);
  logic [DVSR_W-1:0] d_q, cnt_q, d_eff;
  assign d_eff = (dvsr_i == '0) ? DVSR_W'(1) : dvsr_i;
  assign tick_o = en_i && cnt_q == '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      d_q <= DVSR_W'(1);
      cnt_q <= '0;
    end else if (start_i) begin
      d_q <= d_eff;
      cnt_q <= d_eff - 1'b1;
    end else if (tick_o) cnt_q <= d_q - 1'b1;
    else if (en_i) cnt_q <= cnt_q - 1'b1;
endmodule

// File: rtl/spi_master_mc.sv
// spi_master_mc: multi-slave SPI master with per-transfer mode, divisor, bit order and target
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DVSR_W = 16,
  parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [SEL_W-1:0]  ss_sel_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic              miso_i,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic [NUM_SS-1:0] ss_no,
  output logic [DATA_W-1:0] dout_o,
  output logic              ready_o,
  output logic              spi_done_tick_o
);
  localparam int K_W = $clog2(2 * DATA_W);
  localparam logic [K_W-1:0] K_LAST = K_W'(2 * DATA_W - 1);
  spi_state_e state_q, state_d;
  spi_mode_t mode_q;
  logic [K_W-1:0] k_q, k_nx;
  logic [DATA_W-1:0] tx_q, rx_q, tx_src, tx_shift;
  logic [NUM_SS-1:0] sel_hot;
  logic tick, accept, lsb, tx_bit, step, drive, sample;

  spi_clk_div #(.DVSR_W(DVSR_W)) u_div (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(accept), .en_i(state_q != IDLE),
    .dvsr_i(dvsr_i), .tick_o(tick)
  );

  assign ready_o = state_q == IDLE;
  assign accept = ready_o && start_i;
  // On accept the shifter works on din_i directly so cpha=0 can present its first bit in LEAD
  assign lsb = accept ? lsb_first_i : mode_q.lsb_first;
  assign tx_src = accept ? din_i : tx_q;
  assign tx_bit = lsb ? tx_src[0] : tx_src[DATA_W-1];
  assign tx_shift = lsb ? tx_src >> 1 : tx_src << 1;
  assign k_nx = (state_q == LEAD) ? '0 : k_q + 1'b1;
  assign step = tick && state_d == XFER;
  assign sample = step && k_nx[0] == mode_q.cpha;
  assign drive = step && k_nx[0] != mode_q.cpha && k_nx != K_LAST;

  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < NUM_SS; i++) sel_hot[i] = ss_sel_i == SEL_W'(i);
  end

  always_comb begin
    state_d = state_q;
    if (accept) state_d = LEAD;
    else if (tick) state_d = (state_q == LEAD) ? XFER : (state_q == XFER && k_q != K_LAST) ? XFER : (state_q == XFER) ? TRAIL : IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      mode_q <= '0;
      k_q <= '0;
      tx_q <= '0;
      rx_q <= '0;
      sclk_o <= 1'b0;
      mosi_o <= 1'b0;
      ss_no <= '1;
      dout_o <= '0;
      spi_done_tick_o <= 1'b0;
    end else begin
      spi_done_tick_o <= tick && state_q == TRAIL;
      if (accept) begin
        mode_q <= {cpol_i, cpha_i, lsb_first_i};
        ss_no <= ~sel_hot;
        sclk_o <= cpol_i;
        tx_q <= cpha_i ? din_i : tx_shift;
        mosi_o <= !cpha_i && tx_bit;
      end else if (state_q == IDLE) sclk_o <= cpol_i;
      else if (tick) begin
        k_q <= k_nx;
        sclk_o <= step ? mode_q.cpol ^ ~k_nx[0] : mode_q.cpol;
        if (state_q == TRAIL) begin
          ss_no <= '1;
          mosi_o <= 1'b0;
          dout_o <= rx_q;
        end
        if (drive) begin
          mosi_o <= tx_bit;
          tx_q <= tx_shift;
        end
        if (sample) rx_q <= lsb ? {miso_i, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso_i};
      end
    end
endmodule
